// File: rtl/ov7670_stream_gen.sv
// OV7670 camera emulator: produces VSYNC/HREF/D in RGB444 byte order, one byte per clk,
// with colour bars, ramp or solid frame content.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | outputs low, waiting for enable
// ST_VSYNC  | vsync high for VS_LINES line periods
// ST_VBACK  | V_BACK idle line periods before the first active line
// ST_ACTIVE | IMG_H lines: 2*IMG_W bytes with href high, then H_BLANK
// ST_VFRONT | V_FRONT idle line periods; last cycle ends the frame
module ov7670_stream_gen #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int LINE_LEN = 2 * IMG_W + H_BLANK;
  localparam int COL_W    = $clog2(LINE_LEN);
  localparam int LM_A     = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
  localparam int LM_B     = (IMG_H > V_FRONT) ? IMG_H : V_FRONT;
  localparam int LINE_MAX = (LM_A > LM_B) ? LM_A : LM_B;
  localparam int LINE_W   = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_LEN - 1);
  localparam logic [COL_W-1:0]  ACT_BYTES = COL_W'(2 * IMG_W);
  localparam logic [COL_W-1:0]  BAR_W     = COL_W'(IMG_W / 8);
  localparam logic [COL_W-1:0]  NUM_BARS  = COL_W'(8);
  localparam logic [LINE_W-1:0] VS_LAST   = LINE_W'(VS_LINES - 1);
  localparam logic [LINE_W-1:0] VB_LAST   = LINE_W'(V_BACK - 1);
  localparam logic [LINE_W-1:0] ACT_LAST  = LINE_W'(IMG_H - 1);
  localparam logic [LINE_W-1:0] VF_LAST   = LINE_W'(V_FRONT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT
  } state_t;

  state_t            state, n_state;
  logic [COL_W-1:0]  col, n_col;
  logic [LINE_W-1:0] line, n_line;
  logic [LINE_W-1:0] line_last;
  logic [1:0]        pat_sel_q;
  logic [11:0]       pat_solid_q;
  logic              n_start, n_done, n_vsync, n_href;
  logic [7:0]        n_d;
  logic [COL_W-1:0]  px, bar_idx;
  logic [11:0]       rgb;

  // Next position in the frame: column/line counters and state sequencing.
  always_comb begin
    n_state = state;
    n_col   = col;
    n_line  = line;
    n_start = 1'b0;
    case (state)
      ST_VSYNC:  line_last = VS_LAST;
      ST_VBACK:  line_last = VB_LAST;
      ST_ACTIVE: line_last = ACT_LAST;
      ST_VFRONT: line_last = VF_LAST;
      default:   line_last = '0;
    endcase
    case (state)
      ST_IDLE: begin
        if (enable) begin
          n_state = ST_VSYNC;
          n_col   = '0;
          n_line  = '0;
          n_start = 1'b1;
        end
      end
      ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT: begin
        if (col != COL_LAST) begin
          n_col = col + 1'b1;
        end else begin
          n_col = '0;
          if (line != line_last) begin
            n_line = line + 1'b1;
          end else begin
            n_line = '0;
            case (state)
              ST_VSYNC:  n_state = ST_VBACK;
              ST_VBACK:  n_state = ST_ACTIVE;
              ST_ACTIVE: n_state = ST_VFRONT;
              default: begin
                // end of frame: chain straight into the next one when still enabled
                if (enable) begin
                  n_state = ST_VSYNC;
                  n_start = 1'b1;
                end else begin
                  n_state = ST_IDLE;
                end
              end
            endcase
          end
        end
      end
      default: begin
        n_state = ST_IDLE;
        n_col   = '0;
        n_line  = '0;
      end
    endcase
  end

  // Output values for the next position; registered below so every output is a flop.
  always_comb begin
    n_vsync = (n_state == ST_VSYNC);
    n_href  = (n_state == ST_ACTIVE) && (n_col < ACT_BYTES);
    n_done  = (n_state == ST_VFRONT) && (n_col == COL_LAST) && (n_line == VF_LAST);
    px      = n_col >> 1;
    bar_idx = px / BAR_W;
    rgb     = 12'h000;
    case (pat_sel_q)
      2'd1: rgb = {4'(px), 4'(n_line), frame_cnt[3:0]};
      2'd2: rgb = pat_solid_q;
      default: begin
        if (bar_idx < NUM_BARS) begin
          case (bar_idx[2:0])
            3'd0:    rgb = 12'hFFF;
            3'd1:    rgb = 12'hFF0;
            3'd2:    rgb = 12'h0FF;
            3'd3:    rgb = 12'h0F0;
            3'd4:    rgb = 12'hF0F;
            3'd5:    rgb = 12'hF00;
            3'd6:    rgb = 12'h00F;
            default: rgb = 12'h000;
          endcase
        end
      end
    endcase
    n_d = 8'h00;
    if (n_href) n_d = n_col[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
  end

  // State, counters, latched pattern and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      col         <= '0;
      line        <= '0;
      pat_sel_q   <= 2'd0;
      pat_solid_q <= 12'h000;
      vsync       <= 1'b0;
      href        <= 1'b0;
      d           <= 8'h00;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= 16'h0000;
    end else begin
      state       <= n_state;
      col         <= n_col;
      line        <= n_line;
      vsync       <= n_vsync;
      href        <= n_href;
      d           <= n_d;
      frame_start <= n_start;
      frame_done  <= n_done;
      if (n_done) frame_cnt <= frame_cnt + 16'd1;
      if (n_start) begin
        pat_sel_q   <= pattern_sel;
        pat_solid_q <= solid_rgb;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Randomized bench for ov7670_stream_gen against a frame-position reference model.
module tb_ov7670_stream_gen;

  localparam int IMG_W    = 8;
  localparam int IMG_H    = 4;
  localparam int H_BLANK  = 4;
  localparam int VS_LINES = 1;
  localparam int V_BACK   = 1;
  localparam int V_FRONT  = 1;
  localparam int LINE_LEN = 2 * IMG_W + H_BLANK;
  localparam int FRAME    = (VS_LINES + V_BACK + IMG_H + V_FRONT) * LINE_LEN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [11:0] solid_rgb = 12'h000;
  logic        vsync, href, frame_start, frame_done;
  logic [7:0]  d;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state: position within the frame, not the DUT's encoding
  bit          m_run = 1'b0;
  int          m_t = 0;
  logic [1:0]  m_sel = 2'd0;
  logic [11:0] m_solid = 12'h000;
  int          m_cnt = 0;
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                            12'hF0F, 12'hF00, 12'h00F, 12'h000};

  ov7670_stream_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .H_BLANK(H_BLANK),
    .VS_LINES(VS_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .vsync(vsync), .href(href), .d(d),
    .frame_start(frame_start), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] pix_rgb(input int x, input int y);
    int bar;
    if (m_sel == 2'd1) return {4'(x), 4'(y), 4'(m_cnt)};
    if (m_sel == 2'd2) return m_solid;
    bar = x / (IMG_W / 8);
    return (bar < 8) ? bars[bar] : 12'h000;
  endfunction

  task automatic start_frame();
    m_run   = 1'b1;
    m_t     = 0;
    m_sel   = pattern_sel;
    m_solid = solid_rgb;
  endtask

  // advance the model across one rising edge using the inputs the DUT sees
  task automatic model_edge();
    if (!rst_n) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (!m_run) begin
      if (enable) start_frame();
    end else if (m_t == FRAME - 1) begin
      if (enable) start_frame();
      else m_run = 1'b0;
    end else begin
      m_t++;
      if (m_t == FRAME - 1) m_cnt = (m_cnt + 1) & 16'hFFFF;
    end
  endtask

  task automatic check_outputs();
    int lp, col, y;
    logic [11:0] rgb;
    logic ev, eh, efs, efd;
    logic [7:0] ed;
    ev = 0; eh = 0; efs = 0; efd = 0; ed = 8'h00;
    if (m_run) begin
      lp  = m_t / LINE_LEN;
      col = m_t % LINE_LEN;
      y   = lp - VS_LINES - V_BACK;
      ev  = (lp < VS_LINES);
      eh  = (y >= 0) && (y < IMG_H) && (col < 2 * IMG_W);
      if (eh) begin
        rgb = pix_rgb(col / 2, y);
        ed  = (col % 2 == 1) ? rgb[7:0] : {4'h0, rgb[11:8]};
      end
      efs = (m_t == 0);
      efd = (m_t == FRAME - 1);
    end
    check("vsync", 32'(vsync), 32'(ev));
    check("href", 32'(href), 32'(eh));
    check("d", 32'(d), 32'(ed));
    check("frame_start", 32'(frame_start), 32'(efs));
    check("frame_done", 32'(frame_done), 32'(efd));
    check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    pattern_sel = 2'($urandom_range(0, 3));
    solid_rgb   = 12'($urandom);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) step();

    // continuous frames, pattern inputs scrambled every cycle
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (4 * FRAME + 7) step();

    // enable toggled at random points, including mid-frame and at frame end
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      step();
    end

    // asynchronous reset while an active line is being sent
    enable = 1'b1;
    n = 0;
    while (href !== 1'b1 && n < 4 * FRAME) begin
      step();
      n++;
    end
    check("href_before_reset", 32'(href), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    m_run = 1'b0;
    m_cnt = 0;
    check("async_href", 32'(href), 32'd0);
    check("async_vsync", 32'(vsync), 32'd0);
    check("async_d", 32'(d), 32'd0);
    check("async_frame_cnt", 32'(frame_cnt), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2 * FRAME + 5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
